// File: rtl/lcd_cmd_sched.sv
// Round-robin command scheduler (requesters A/B) feeding a DEPTH-entry FIFO that issues one command at a time to the LCD engine.
// Optional LCD_SCHED_BYPASS_EN: a legal command arriving at an idle, empty scheduler issues directly (1-edge latency instead of 2).
module lcd_cmd_sched #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       a_cmd,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [3:0]       b_cmd,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [3:0]       eng_cmd,
  output logic             eng_cmd_valid,
  input  logic             eng_busy,
  input  logic             eng_done,
  output logic             sched_idle,
  output logic             halted,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GUARD = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [3:0]     LAST_LEGAL = 4'd11;
  localparam logic [3:0]     WRITE_CMD  = 4'd0;
  localparam logic [PTR_W:0] FULL_CNT   = (PTR_W+1)'(DEPTH);

  logic [1:0]       r_state;
  logic [3:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             r_last_b;
  logic             r_is_write;
  logic [3:0]       r_eng_cmd;
  logic             r_eng_cmd_valid;
  logic [ERR_W-1:0] r_err_cnt;

  logic       w_halted;
  logic       w_empty;
  logic       w_can_push;
  logic       w_grant_a;
  logic       w_grant_b;
  logic       w_acc;
  logic [3:0] w_acc_cmd;
  logic       w_acc_legal;
  logic       w_acc_illegal;
  logic       w_issue_fifo;
  logic       w_bypass;
  logic       w_issue;
  logic [3:0] w_issue_cmd;
  logic       w_push;
  logic       w_pop;

  assign w_halted   = (r_state == S_HALT);
  assign w_empty    = (r_count == '0);
  assign w_can_push = (r_count < FULL_CNT) && !w_halted;

  // Contention goes to whoever did not win last; last grant resets to B so A wins first.
  assign w_grant_a = a_valid && (!b_valid || r_last_b);
  assign w_grant_b = b_valid && !w_grant_a;
  assign a_ready   = w_can_push && w_grant_a;
  assign b_ready   = w_can_push && w_grant_b;

  assign w_acc         = a_ready || b_ready;
  assign w_acc_cmd     = a_ready ? a_cmd : b_cmd;
  assign w_acc_legal   = w_acc && (w_acc_cmd <= LAST_LEGAL);
  assign w_acc_illegal = w_acc && (w_acc_cmd > LAST_LEGAL);

  assign w_issue_fifo = (r_state == S_IDLE) && !w_empty && !eng_busy;
`ifdef LCD_SCHED_BYPASS_EN
  assign w_bypass = (r_state == S_IDLE) && w_empty && !eng_busy && w_acc_legal;
`else
  assign w_bypass = 1'b0;
`endif
  assign w_issue     = w_issue_fifo || w_bypass;
  assign w_issue_cmd = w_issue_fifo ? r_mem[r_rptr] : w_acc_cmd;
  assign w_push      = w_acc_legal && !w_bypass;
  assign w_pop       = w_issue_fifo;

  // Storage carries no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_acc_cmd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_last_b <= 1'b1;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_acc) begin
        r_last_b <= b_ready;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (w_acc_illegal && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_eng_cmd       <= '0;
      r_eng_cmd_valid <= 1'b0;
      r_is_write      <= 1'b0;
    end else begin
      r_eng_cmd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_eng_cmd       <= w_issue_cmd;
            r_eng_cmd_valid <= 1'b1;
            r_is_write      <= (w_issue_cmd == WRITE_CMD);
            r_state         <= S_GUARD;
          end
        end
        // Engine status is not trusted in the cycle right after the strobe.
        S_GUARD: r_state <= S_WAIT;
        S_WAIT: begin
          if (r_is_write) begin
            if (eng_done) begin
              r_state <= S_HALT;
            end
          end else if (!eng_busy) begin
            r_state <= S_IDLE;
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign eng_cmd       = r_eng_cmd;
  assign eng_cmd_valid = r_eng_cmd_valid;
  assign sched_idle    = (r_state == S_IDLE) && w_empty;
  assign halted        = w_halted;
  assign err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Bench for lcd_cmd_sched: queue-based reference model compared every cycle, plus directed scenarios with literal expectations.
module tb_lcd_cmd_sched;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] a_cmd = '0;
  logic       a_valid = 1'b0;
  logic       a_ready;
  logic [3:0] b_cmd = '0;
  logic       b_valid = 1'b0;
  logic       b_ready;
  logic [3:0] eng_cmd;
  logic       eng_cmd_valid;
  logic       eng_busy = 1'b0;
  logic       eng_done = 1'b0;
  logic       sched_idle;
  logic       halted;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  lcd_cmd_sched #(.DEPTH(8), .PTR_W(3), .ERR_W(8)) dut (
    .clk(clk), .reset(reset),
    .a_cmd(a_cmd), .a_valid(a_valid), .a_ready(a_ready),
    .b_cmd(b_cmd), .b_valid(b_valid), .b_ready(b_ready),
    .eng_cmd(eng_cmd), .eng_cmd_valid(eng_cmd_valid),
    .eng_busy(eng_busy), .eng_done(eng_done),
    .sched_idle(sched_idle), .halted(halted), .err_cnt(err_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending commands, whether one is out at the engine, and how many edges ago it was issued.
  int         mq[$];
  bit         m_last_b;
  bit         m_halted;
  bit         m_inflight;
  int         m_age;
  bit         m_wr;
  int         m_err;
  bit         m_vld;
  logic [3:0] m_cmd;

  int issued[$];
  int acc_log[$];

  task automatic m_reset();
    mq.delete();
    m_last_b   = 1'b1;
    m_halted   = 1'b0;
    m_inflight = 1'b0;
    m_age      = 0;
    m_wr       = 1'b0;
    m_err      = 0;
    m_vld      = 1'b0;
    m_cmd      = '0;
  endtask

  task automatic m_issue(input int c);
    m_vld      = 1'b1;
    m_cmd      = 4'(c);
    m_inflight = 1'b1;
    m_age      = 0;
    m_wr       = (c == 0);
  endtask

  task automatic m_step();
    bit can, ga, acc_a, acc_b, pre_inflight;
    int c, pre_size;
    pre_size     = mq.size();
    pre_inflight = m_inflight;
    can   = (pre_size < DEPTH) && !m_halted;
    ga    = a_valid && (!b_valid || m_last_b);
    acc_a = can && ga;
    acc_b = can && b_valid && !ga;
    c     = acc_a ? int'(a_cmd) : int'(b_cmd);
    m_vld = 1'b0;
    if (m_inflight) begin
      if (m_age >= 1) begin
        if (!m_wr && !eng_busy) m_inflight = 1'b0;
        else if (m_wr && eng_done) begin
          m_inflight = 1'b0;
          m_halted   = 1'b1;
        end
      end
      m_age++;
    end else if (!m_halted && !eng_busy && pre_size > 0) begin
      m_issue(mq.pop_front());
    end
    if (acc_a || acc_b) begin
      m_last_b = acc_b;
      if (c >= 12) begin
        if (m_err < 255) m_err++;
      end
`ifdef LCD_SCHED_BYPASS_EN
      else if (!pre_inflight && !m_halted && pre_size == 0 && !eng_busy) m_issue(c);
`endif
      else mq.push_back(c);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) m_reset();
    else m_step();
  end

  always @(negedge clk) begin
    bit can, ga;
    can = (mq.size() < DEPTH) && !m_halted;
    ga  = a_valid && (!b_valid || m_last_b);
    chk("a_ready", a_ready, can && ga);
    chk("b_ready", b_ready, can && b_valid && !ga);
    chk("eng_cmd_valid", eng_cmd_valid, m_vld);
    chk("eng_cmd", eng_cmd, m_cmd);
    chk("sched_idle", sched_idle, !m_inflight && !m_halted && mq.size() == 0);
    chk("halted", halted, m_halted);
    chk("err_cnt", err_cnt, m_err);
    if (eng_cmd_valid) issued.push_back(int'(eng_cmd));
    if (a_ready) acc_log.push_back(0);
    if (b_ready) acc_log.push_back(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_valid  = 1'b0;
    b_valid  = 1'b0;
    eng_busy = 1'b0;
    eng_done = 1'b0;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    tick();
    issued.delete();
    acc_log.delete();
  endtask

  task automatic send(input bit use_b, input logic [3:0] c);
    int n;
    n = 0;
    if (use_b) begin b_cmd = c; b_valid = 1'b1; end
    else begin a_cmd = c; a_valid = 1'b1; end
    at_neg();
    while (!(use_b ? b_ready : a_ready) && n < 50) begin
      at_neg();
      n++;
    end
    chk("send_accepted", n < 50, 1);
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic wait_issues(input int n, input int budget);
    int k;
    k = 0;
    while (issued.size() < n && k < budget) begin
      at_neg();
      k++;
    end
    chk("issue_count", issued.size(), n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_acc[4];
    int exp_iss[4];
    exp_acc = '{0, 1, 0, 1};
    exp_iss = '{1, 2, 1, 2};

    // Reset values and single-command latency
    do_reset();
    at_neg();
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_vld", eng_cmd_valid, 0);
    chk("rst_cmd", eng_cmd, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_idle", sched_idle, 1);
    tick();
    a_cmd = 4'd4;
    a_valid = 1'b1;
    at_neg();
    chk("t1_a_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    at_neg();
`ifdef LCD_SCHED_BYPASS_EN
    chk("t1_vld_e0", eng_cmd_valid, 1);
    chk("t1_cmd", eng_cmd, 4);
    at_neg();
    chk("t1_vld_end", eng_cmd_valid, 0);
`else
    chk("t1_vld_e0", eng_cmd_valid, 0);
    at_neg();
    chk("t1_vld_e1", eng_cmd_valid, 1);
    chk("t1_cmd", eng_cmd, 4);
    at_neg();
    chk("t1_vld_end", eng_cmd_valid, 0);
`endif
    repeat (5) tick();
    chk("t1_issued_once", issued.size(), 1);

    // Round-robin under constant contention
    do_reset();
    a_cmd = 4'd1;
    b_cmd = 4'd2;
    a_valid = 1'b1;
    b_valid = 1'b1;
    repeat (4) tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    chk("t2_acc_count", acc_log.size(), 4);
    for (int i = 0; i < 4 && i < acc_log.size(); i++) chk("t2_acc_order", acc_log[i], exp_acc[i]);
    wait_issues(4, 40);
    for (int i = 0; i < 4 && i < issued.size(); i++) chk("t2_issue_order", issued[i], exp_iss[i]);

    // Fill while engine busy, ninth waits for the first pop
    do_reset();
    eng_busy = 1'b1;
    for (int i = 1; i <= 8; i++) send(1'b0, 4'(i));
    a_cmd = 4'd9;
    a_valid = 1'b1;
    repeat (3) begin
      at_neg();
      chk("t3_full_ready", a_ready, 0);
    end
    tick();
    eng_busy = 1'b0;
    at_neg();
    chk("t3_ready_before_pop", a_ready, 0);
    send(1'b0, 4'd9);
    wait_issues(9, 80);
    for (int i = 0; i < issued.size(); i++) chk("t3_issue_order", issued[i], i + 1);

    // Illegal codes are accepted and counted, never issued
    do_reset();
    send(1'b0, 4'd13);
    send(1'b1, 4'd15);
    send(1'b0, 4'd3);
    wait_issues(1, 20);
    repeat (6) tick();
    chk("t4_err_cnt", err_cnt, 2);
    chk("t4_issue_count", issued.size(), 1);
    if (issued.size() > 0) chk("t4_issue_cmd", issued[0], 3);

    // WRITE completion halts the scheduler
    do_reset();
    send(1'b0, 4'd5);
    send(1'b0, 4'd0);
    send(1'b1, 4'd6);
    wait_issues(2, 30);
    repeat (4) @(posedge clk);
    #1;
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    at_neg();
    chk("t5_halted", halted, 1);
    if (issued.size() >= 2) begin
      chk("t5_first", issued[0], 5);
      chk("t5_second", issued[1], 0);
    end
    a_cmd = 4'd7;
    a_valid = 1'b1;
    b_cmd = 4'd8;
    b_valid = 1'b1;
    repeat (3) begin
      at_neg();
      chk("t5_a_ready_halted", a_ready, 0);
      chk("t5_b_ready_halted", b_ready, 0);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (10) tick();
    chk("t5_no_more_issue", issued.size(), 2);
    do_reset();
    at_neg();
    chk("t5_post_rst_halted", halted, 0);
    chk("t5_post_rst_idle", sched_idle, 1);
    repeat (10) tick();
    chk("t5_post_rst_issue", issued.size(), 0);

    // Reset in WAIT with entries queued
    do_reset();
    eng_busy = 1'b1;
    send(1'b0, 4'd2);
    send(1'b0, 4'd3);
    send(1'b0, 4'd4);
    send(1'b0, 4'd5);
    eng_busy = 1'b0;
    tick();
    eng_busy = 1'b1;
    repeat (3) tick();
    chk("t6_one_issued", issued.size(), 1);
    chk("t6_not_idle", sched_idle, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_vld", eng_cmd_valid, 0);
    chk("t6_rst_cmd", eng_cmd, 0);
    chk("t6_rst_idle", sched_idle, 1);
    chk("t6_rst_halted", halted, 0);
    chk("t6_rst_err", err_cnt, 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    eng_busy = 1'b0;
    issued.delete();
    repeat (15) tick();
    chk("t6_no_issue_after_rst", issued.size(), 0);
    chk("t6_idle_after_rst", sched_idle, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
